// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin arbiter for the single pixel-write port of
// the 160x120 video memory, with a built-in full-screen clear engine.
// Optional feature macro: VGA_WRITE_ARB_VSYNC_CLEAR_EN. When it is defined, a
// clear waits for the next frame_sync pulse before sweeping. When it is not
// defined, the sweep starts immediately and frame_sync is ignored.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_ARB       | round-robin grants to requesters; clear_start is accepted
// ST_WAIT_SYNC | clear accepted, waiting for frame_sync (macro only)
// ST_CLEAR     | raster sweep writing the fill colour, one pixel per cycle
module vga_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int COLOUR_BITS = 9,
  parameter int X_PIXELS    = 160,
  parameter int Y_PIXELS    = 120
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [8*NUM_REQ-1:0]           req_x_i,
  input  logic [7*NUM_REQ-1:0]           req_y_i,
  input  logic [COLOUR_BITS*NUM_REQ-1:0] req_colour_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic                           clear_start_i,
  input  logic [COLOUR_BITS-1:0]         clear_colour_i,
  input  logic                           frame_sync_i,
  output logic                           clear_busy_o,
  output logic                           oob_o,
  output logic                           plot_o,
  output logic [7:0]                     x_o,
  output logic [6:0]                     y_o,
  output logic [COLOUR_BITS-1:0]         colour_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] X_LIM  = 8'(X_PIXELS);
  localparam logic [7:0] X_LAST = 8'(X_PIXELS - 1);
  localparam logic [6:0] Y_LIM  = 7'(Y_PIXELS);
  localparam logic [6:0] Y_LAST = 7'(Y_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
`ifdef VGA_WRITE_ARB_VSYNC_CLEAR_EN
    ST_WAIT_SYNC = 2'd1,
`endif
    ST_CLEAR     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   plot_q, plot_d;
  logic                   oob_q, oob_d;
  logic [7:0]             x_q, x_d;
  logic [6:0]             y_q, y_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;
  logic [7:0]             cx_q, cx_d;
  logic [6:0]             cy_q, cy_d;
  logic [COLOUR_BITS-1:0] fill_q, fill_d;

  logic                   gnt_found;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   arb_en;
  logic                   transfer;
  logic [7:0]             sel_x;
  logic [6:0]             sel_y;
  logic [COLOUR_BITS-1:0] sel_colour;

`ifndef VGA_WRITE_ARB_VSYNC_CLEAR_EN
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync_i;
`endif

  // Round-robin search: first valid requester starting just above the last winner.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // Grant is only offered in ARB and never during the reset cycle.
  always_comb begin
    arb_en      = (state_q == ST_ARB) && !reset_i;
    transfer    = arb_en && gnt_found;
    req_ready_o = '0;
    req_ready_o[gnt_idx] = transfer;
    sel_x      = req_x_i[int'(gnt_idx)*8 +: 8];
    sel_y      = req_y_i[int'(gnt_idx)*7 +: 7];
    sel_colour = req_colour_i[int'(gnt_idx)*COLOUR_BITS +: COLOUR_BITS];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    plot_d   = 1'b0;
    oob_d    = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    fill_d   = fill_q;
    case (state_q)
      ST_ARB: begin
        if (transfer) begin
          last_d = gnt_idx;
          if ((sel_x < X_LIM) && (sel_y < Y_LIM)) begin
            plot_d   = 1'b1;
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_colour;
          end else begin
            oob_d = 1'b1;
          end
        end
        if (clear_start_i) begin
          fill_d = clear_colour_i;
          cx_d   = '0;
          cy_d   = '0;
`ifdef VGA_WRITE_ARB_VSYNC_CLEAR_EN
          state_d = ST_WAIT_SYNC;
`else
          state_d = ST_CLEAR;
`endif
        end
      end
`ifdef VGA_WRITE_ARB_VSYNC_CLEAR_EN
      ST_WAIT_SYNC: begin
        if (frame_sync_i) state_d = ST_CLEAR;
      end
`endif
      ST_CLEAR: begin
        plot_d   = 1'b1;
        x_d      = cx_q;
        y_d      = cy_q;
        colour_d = fill_q;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            state_d = ST_ARB;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_ARB;
      last_q   <= IDX_W'(NUM_REQ - 1);
      plot_q   <= 1'b0;
      oob_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      plot_q   <= plot_d;
      oob_q    <= oob_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      fill_q   <= fill_d;
    end
  end

  assign clear_busy_o = (state_q != ST_ARB);
  assign plot_o       = plot_q;
  assign oob_o        = oob_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign colour_o     = colour_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Testbench for vga_write_arbiter: directed scenarios plus randomized
// requester traffic, compared every cycle against a behavioural model.
module tb_vga_write_arbiter;

  localparam int N  = 4;
  localparam int CB = 9;
  localparam int XP = 160;
  localparam int YP = 120;
  localparam int NPIX = XP * YP;

  logic                clock = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [8*N-1:0]      req_x;
  logic [7*N-1:0]      req_y;
  logic [CB*N-1:0]     req_colour;
  logic [N-1:0]        req_ready;
  logic                clear_start;
  logic [CB-1:0]       clear_colour;
  logic                frame_sync;
  logic                clear_busy, oob, plot;
  logic [7:0]          x;
  logic [6:0]          y;
  logic [CB-1:0]       colour;

  int checks = 0;
  int errors = 0;

  // requester intent as the bench sees it
  bit rq_v[N];
  int rq_x[N], rq_y[N], rq_c[N];
  bit hold_reqs = 0;

  // behavioural model: mode 0 idle, 1 waiting for sync, 2 sweeping
  int          m_last, m_mode, m_idx, m_gnt;
  logic [CB-1:0] m_fill;
  logic        e_plot, e_oob;
  int          e_x, e_y;
  logic [CB-1:0] e_col;
  logic [N-1:0] obs_ready;

  vga_write_arbiter #(.NUM_REQ(N), .COLOUR_BITS(CB), .X_PIXELS(XP), .Y_PIXELS(YP)) dut (
    .clock_i(clock), .reset_i(reset),
    .req_valid_i(req_valid), .req_x_i(req_x), .req_y_i(req_y), .req_colour_i(req_colour),
    .req_ready_o(req_ready),
    .clear_start_i(clear_start), .clear_colour_i(clear_colour), .frame_sync_i(frame_sync),
    .clear_busy_o(clear_busy), .oob_o(oob), .plot_o(plot),
    .x_o(x), .y_o(y), .colour_o(colour)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = rq_v[i];
      req_x[i*8 +: 8]          = 8'(rq_x[i]);
      req_y[i*7 +: 7]          = 7'(rq_y[i]);
      req_colour[i*CB +: CB]   = CB'(rq_c[i]);
    end
  endtask

  function automatic int model_grant();
    if (reset || m_mode != 0) return -1;
    for (int k = 1; k <= N; k++) begin
      if (rq_v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (reset) begin
      m_mode = 0; m_last = N - 1;
      e_plot = 0; e_oob = 0; e_x = 0; e_y = 0; e_col = '0;
      return;
    end
    e_plot = 0; e_oob = 0;
    case (m_mode)
      0: begin
        if (g >= 0) begin
          m_last = g;
          if (rq_x[g] < XP && rq_y[g] < YP) begin
            e_plot = 1; e_x = rq_x[g]; e_y = rq_y[g]; e_col = CB'(rq_c[g]);
          end else begin
            e_oob = 1;
          end
        end
        if (clear_start) begin
          m_fill = clear_colour;
          m_idx  = 0;
`ifdef VGA_WRITE_ARB_VSYNC_CLEAR_EN
          m_mode = 1;
`else
          m_mode = 2;
`endif
        end
      end
      1: if (frame_sync) m_mode = 2;
      default: begin
        e_plot = 1; e_x = m_idx % XP; e_y = m_idx / XP; e_col = m_fill;
        m_idx++;
        if (m_idx == NPIX) m_mode = 0;
      end
    endcase
  endtask

  // One clock cycle: check grant before the edge, outputs after it.
  task automatic tick();
    logic [N-1:0] exp_ready;
    drive_reqs();
    #1;
    m_gnt = model_grant();
    exp_ready = '0;
    if (m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", req_ready, exp_ready);
    @(posedge clock);
    model_edge(m_gnt);
    @(negedge clock);
    chk("plot", plot, e_plot);
    chk("oob", oob, e_oob);
    chk("clear_busy", clear_busy, m_mode != 0);
    chk("x", x, e_x);
    chk("y", y, e_y);
    chk("colour", colour, e_col);
    if (!hold_reqs && m_gnt >= 0) rq_v[m_gnt] = 0;
  endtask

  task automatic set_req(input int i, input int xx, input int yy, input int cc);
    rq_v[i] = 1; rq_x[i] = xx; rq_y[i] = yy; rq_c[i] = cc;
  endtask

  // Issue clear_start and, in the sync-gated build, release it with frame_sync.
  task automatic start_clear(input logic [CB-1:0] col);
    clear_start = 1; clear_colour = col;
    tick();
    clear_start = 0; clear_colour = '0;
`ifdef VGA_WRITE_ARB_VSYNC_CLEAR_EN
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("wait_no_plot", plot, 1'b0);
    end
    frame_sync = 1;
    tick();
    frame_sync = 0;
    chk("sync_plus1_no_plot", plot, 1'b0);
    tick();
    chk("sync_plus2_plot", plot, 1'b1);
`endif
  endtask

  initial begin
    int cnt;
    int seen;
    reset = 1; clear_start = 0; clear_colour = '0; frame_sync = 0;
    req_valid = '0; req_x = '0; req_y = '0; req_colour = '0;
    for (int i = 0; i < N; i++) begin rq_v[i] = 0; rq_x[i] = 0; rq_y[i] = 0; rq_c[i] = 0; end
    m_last = N - 1; m_mode = 0; m_idx = 0; m_gnt = -1; m_fill = '0;
    e_plot = 0; e_oob = 0; e_x = 0; e_y = 0; e_col = '0;
    #2;
    tick(); tick();
    chk("reset_plot", plot, 1'b0);
    chk("reset_busy", clear_busy, 1'b0);
    reset = 0;

    // all four requesters held valid: strict rotation 0,1,2,3,0,1,2,3
    hold_reqs = 1;
    for (int i = 0; i < N; i++) set_req(i, 10 + i * 20, 3 + i * 11, 9'h040 + i * 9'h015);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr_sequence", obs_ready, 4'b0001 << (c % 4));
      chk("rr_plot", plot, 1'b1);
    end
    hold_reqs = 0;
    for (int i = 0; i < N; i++) rq_v[i] = 0;
    tick();

    // single requester
    set_req(2, 5, 7, 9'h1FF);
    tick();
    chk("single_ready", obs_ready, 4'b0100);
    chk("single_x", x, 8'd5);
    chk("single_y", y, 7'd7);
    chk("single_colour", colour, 9'h1FF);

    // out-of-range requests
    set_req(1, 160, 0, 9'h011);
    tick();
    chk("oob_x_plot", plot, 1'b0);
    chk("oob_x_flag", oob, 1'b1);
    set_req(1, 0, 120, 9'h022);
    tick();
    chk("oob_y_plot", plot, 1'b0);
    chk("oob_y_flag", oob, 1'b1);
    tick();
    chk("oob_pulse_end", oob, 1'b0);

    // full clear, with a requester waiting and a second clear_start mid-sweep
    set_req(3, 40, 40, 9'h155);
    start_clear(9'h0A5);
`ifdef VGA_WRITE_ARB_VSYNC_CLEAR_EN
    cnt = 1;
`else
    cnt = 0;
`endif
    seen = 0;
    while (cnt < NPIX && seen < NPIX + 50) begin
      clear_start  = (cnt == 300);
      clear_colour = (cnt == 300) ? 9'h1FF : 9'h000;
      tick();
      seen++;
      if (plot) begin
        cnt++;
        if (cnt == 1)   begin chk("clr_first_x", x, 0);   chk("clr_first_y", y, 0);   end
        if (cnt == 160) begin chk("clr_160_x", x, 159);   chk("clr_160_y", y, 0);     end
        if (cnt == NPIX) begin
          chk("clr_last_x", x, 159); chk("clr_last_y", y, 119);
          chk("clr_busy_falls", clear_busy, 1'b0);
        end
        chk("clr_colour", colour, 9'h0A5);
      end
    end
    clear_start = 0;
    chk("clr_count", cnt, NPIX);
    tick();
    tick();

    // reset during a clear
    start_clear(9'h123);
`ifdef VGA_WRITE_ARB_VSYNC_CLEAR_EN
    cnt = 1;
`else
    cnt = 0;
`endif
    seen = 0;
    while (cnt < 500 && seen < 600) begin
      tick();
      seen++;
      if (plot) cnt++;
    end
    chk("pre_reset_count", cnt, 500);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid_plot", plot, 1'b0);
    chk("rst_mid_busy", clear_busy, 1'b0);
    set_req(0, 1, 2, 9'h0F0);
    tick();
    chk("post_reset_grant", obs_ready, 4'b0001);
    chk("post_reset_plot", plot, 1'b1);

    // randomized traffic obeying hold-until-ready
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_v[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 511));
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
